// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// spi_xfer_arbiter: round-robin sequencer of multi-word SPI transactions from two
// requesters onto one shared spi_core, with programmable slave-select lead/trail.
module spi_xfer_arbiter #(
  parameter int DWIDTH   = 8,
  parameter int LEN_W    = 8,
  parameter int SS_LEAD  = 2,
  parameter int SS_TRAIL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [2*LEN_W-1:0]  req_len,
  input  logic [2*DWIDTH-1:0] tx_data,
  output logic [1:0]          tx_ack,
  output logic [DWIDTH-1:0]   rx_data,
  output logic [1:0]          rx_valid,
  output logic [1:0]          gnt,
  output logic [1:0]          xfer_done,
  output logic                busy,
  output logic [1:0]          ss_n,
  output logic                core_cs,
  output logic                core_wr,
  output logic                core_rd,
  output logic [DWIDTH-1:0]   core_din,
  input  logic [DWIDTH-1:0]   core_dout,
  input  logic                core_done
);

  localparam int CNT_MAX = (SS_LEAD > SS_TRAIL) ? SS_LEAD : SS_TRAIL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    LOAD  = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4,
    TRAIL = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sel;
  logic               last;
  logic [LEN_W-1:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic               pick;
  logic [LEN_W-1:0]   pick_len;
  logic               cnt_last;

  // On a tie the requester not served last wins; last resets to 1 so requester 0 wins first.
  always_comb begin
    pick     = (req == 2'b11) ? ~last : req[1];
    pick_len = pick ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    cnt_last = (cnt == CNT_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LEAD;
      LEAD:    if (cnt_last) state_nxt = (rem == '0) ? TRAIL : LOAD;
      LOAD:    state_nxt = GUARD;
      GUARD:   state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = (rem == LEN_W'(1)) ? TRAIL : LOAD;
      TRAIL:   if (cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_cs  = (state == LOAD);
    core_wr  = (state == LOAD);
    core_rd  = 1'b0;
    tx_ack   = (state == LOAD) ? gnt : 2'b00;
    busy     = (state != IDLE);
    core_din = sel ? tx_data[2*DWIDTH-1:DWIDTH] : tx_data[DWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      rem       <= '0;
      cnt       <= '0;
      gnt       <= 2'b00;
      ss_n      <= 2'b11;
      rx_data   <= '0;
      rx_valid  <= 2'b00;
      xfer_done <= 2'b00;
    end else begin
      state     <= state_nxt;
      rx_valid  <= 2'b00;
      xfer_done <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            sel  <= pick;
            rem  <= pick_len;
            cnt  <= CNT_W'(SS_LEAD);
            gnt  <= pick ? 2'b10 : 2'b01;
            ss_n <= pick ? 2'b01 : 2'b10;
          end
        end
        LEAD: begin
          if (cnt_last) begin
            if (rem == '0) cnt <= CNT_W'(SS_TRAIL);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WAIT: begin
          if (core_done) begin
            rx_data  <= core_dout;
            rx_valid <= gnt;
            rem      <= rem - LEN_W'(1);
            cnt      <= CNT_W'(SS_TRAIL);
          end
        end
        TRAIL: begin
          if (cnt_last) begin
            ss_n      <= 2'b11;
            gnt       <= 2'b00;
            xfer_done <= gnt;
            last      <= sel;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// tb_spi_xfer_arbiter: two arbiters (lead/trail 2/2 and 1/1) on loopback core models,
// with a transaction/word scoreboard on the first and timing monitors on both.
module tb_spi_xfer_arbiter;

  localparam int DW     = 8;
  localparam int LW     = 8;
  localparam int LAT    = 2;
  localparam int LEAD_A = 2;
  localparam int TRAIL_A = 2;
  localparam int LEAD_B = 1;
  localparam int TRAIL_B = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [2*LW-1:0] req_len = '0;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word(input int i, input int n);
    if (i == 0 && n == 0) return 8'hA5;
    if (i == 0 && n == 1) return 8'h3C;
    if (i == 0 && n == 2) return 8'hFF;
    return 8'((n * 29 + i * 107 + 17) % 256);
  endfunction

  logic [2*DW-1:0] a_tx_data, b_tx_data;
  logic [1:0]      a_tx_ack, b_tx_ack, a_rx_valid, b_rx_valid, a_gnt, b_gnt;
  logic [1:0]      a_xfer_done, b_xfer_done, a_ss_n, b_ss_n;
  logic [DW-1:0]   a_rx_data, b_rx_data, a_core_din, b_core_din;
  logic            a_busy, b_busy, a_core_cs, b_core_cs, a_core_wr, b_core_wr;
  logic            a_core_rd, b_core_rd;
  logic [1:0]      done_m;
  logic [DW-1:0]   dout_m [2];

  spi_xfer_arbiter #(.DWIDTH(DW), .LEN_W(LW), .SS_LEAD(LEAD_A), .SS_TRAIL(TRAIL_A)) u_a (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .tx_data(a_tx_data),
    .tx_ack(a_tx_ack), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .gnt(a_gnt),
    .xfer_done(a_xfer_done), .busy(a_busy), .ss_n(a_ss_n), .core_cs(a_core_cs),
    .core_wr(a_core_wr), .core_rd(a_core_rd), .core_din(a_core_din),
    .core_dout(dout_m[0]), .core_done(done_m[0])
  );

  spi_xfer_arbiter #(.DWIDTH(DW), .LEN_W(LW), .SS_LEAD(LEAD_B), .SS_TRAIL(TRAIL_B)) u_b (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .tx_data(b_tx_data),
    .tx_ack(b_tx_ack), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .gnt(b_gnt),
    .xfer_done(b_xfer_done), .busy(b_busy), .ss_n(b_ss_n), .core_cs(b_core_cs),
    .core_wr(b_core_wr), .core_rd(b_core_rd), .core_din(b_core_din),
    .core_dout(dout_m[1]), .core_done(done_m[1])
  );

  wire [3:0]  ss_all  = {b_ss_n, a_ss_n};
  wire [3:0]  gnt_all = {b_gnt, a_gnt};
  wire [3:0]  ack_all = {b_tx_ack, a_tx_ack};
  wire [3:0]  rxv_all = {b_rx_valid, a_rx_valid};
  wire [3:0]  xd_all  = {b_xfer_done, a_xfer_done};
  wire [1:0]  wr_all  = {b_core_wr, a_core_wr};
  wire [1:0]  cs_all  = {b_core_cs, a_core_cs};
  wire [1:0]  rd_all  = {b_core_rd, a_core_rd};
  wire [15:0] din_all = {b_core_din, a_core_din};
  wire [15:0] rx_all  = {b_rx_data, a_rx_data};

  // Per-instance tx word streams advance on each consumed word.
  int wcnt [2][2];
  assign a_tx_data = {word(1, wcnt[0][1]), word(0, wcnt[0][0])};
  assign b_tx_data = {word(1, wcnt[1][1]), word(0, wcnt[1][0])};

  // Loopback core: done stays high until the cycle after the next write, then
  // rises again LAT+1 cycles later with the written word on dout.
  logic [1:0]    pend, clr;
  int            lat_c [2];
  logic [DW-1:0] sh [2];
  int            wr_cnt [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++)
        if (ack_all[2*k+i]) wcnt[k][i] <= wcnt[k][i] + 1;
      if (!rst) begin
        pend[k]   <= 1'b0;
        clr[k]    <= 1'b0;
        done_m[k] <= 1'b0;
        dout_m[k] <= '0;
      end else if (wr_all[k]) begin
        pend[k]   <= 1'b1;
        clr[k]    <= 1'b1;
        lat_c[k]  <= LAT;
        sh[k]     <= din_all[8*k +: 8];
        wr_cnt[k] <= wr_cnt[k] + 1;
      end else if (clr[k]) begin
        done_m[k] <= 1'b0;
        clr[k]    <= 1'b0;
      end else if (pend[k]) begin
        if (lat_c[k] == 0) begin
          done_m[k] <= 1'b1;
          dout_m[k] <= sh[k];
          pend[k]   <= 1'b0;
        end else begin
          lat_c[k] <= lat_c[k] - 1;
        end
      end
    end
  end

  int            ex_id [$];
  int            ex_len [$];
  int            sb_id [$];
  logic [7:0]    sb_d [$];
  int            cur_id, cur_len, words_a, acks_a;
  logic [1:0]    prev_gnt_a;

  int            cyc = 0;
  logic [1:0]    prev_ss [2];
  int            t_fall [2], t_rx [2], wr_x [2], rxv_x [2];
  bit            first_wr [2];
  logic [1:0]    m_ss, m_g, m_ng, m_ack, m_rxv, m_xd, m_rel;
  logic          m_wr, m_cs, m_rd;
  logic [7:0]    m_rx, m_d;
  int            m_id, m_lead, m_trail;

  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        m_ss = ss_all[2*k +: 2];  m_g  = gnt_all[2*k +: 2];  m_ng = ~m_g;
        m_ack = ack_all[2*k +: 2]; m_rxv = rxv_all[2*k +: 2]; m_xd = xd_all[2*k +: 2];
        m_wr = wr_all[k]; m_cs = cs_all[k]; m_rd = rd_all[k]; m_rx = rx_all[8*k +: 8];
        m_lead  = (k == 0) ? LEAD_A : LEAD_B;
        m_trail = (k == 0) ? TRAIL_A : TRAIL_B;
        if (!rst) begin
          prev_ss[k] = 2'b11; first_wr[k] = 1'b0; wr_x[k] = 0; rxv_x[k] = 0;
        end else begin
          check("ss_vs_gnt", m_ss, m_ng);
          check("core_rd", m_rd, 0);
          if (m_cs != m_wr) check("cs_eq_wr", m_cs, m_wr);
          if (prev_ss[k] == 2'b11 && m_ss != 2'b11) begin
            t_fall[k] = cyc; first_wr[k] = 1'b1; wr_x[k] = 0; rxv_x[k] = 0;
          end
          if (prev_ss[k] != 2'b11 && m_ss != 2'b11 && m_ss != prev_ss[k])
            check("ss_gap", m_ss, prev_ss[k]);
          if (m_wr) begin
            if (first_wr[k]) begin
              check("lead_cycles", cyc - t_fall[k], m_lead);
              first_wr[k] = 1'b0;
            end
            wr_x[k]++;
            check("wr_while_busy", pend[k] | clr[k], 0);
            check("ack_on_wr", m_ack, m_g);
          end else if (m_ack != 2'b00) begin
            check("ack_without_wr", m_ack, 0);
          end
          if (m_rxv != 2'b00) begin
            rxv_x[k]++; t_rx[k] = cyc;
            check("rx_loopback", m_rx, sh[k]);
            check("rxv_to_gnt", m_rxv, m_g);
          end
          if (prev_ss[k] != 2'b11 && m_ss == 2'b11) begin
            m_rel = ~prev_ss[k];
            if (rxv_x[k] != 0) check("trail_cycles", cyc - t_rx[k], m_trail);
            else               check("lead_trail_cycles", cyc - t_fall[k], m_lead + m_trail);
            check("xfer_done_at_release", m_xd, m_rel);
            check("wr_per_word", wr_x[k], rxv_x[k]);
          end else if (m_xd != 2'b00) begin
            check("xfer_done_spurious", m_xd, 0);
          end
          prev_ss[k] = m_ss;
        end
      end
      // Transaction and word scoreboard for the first instance.
      if (!rst) begin
        sb_id.delete(); sb_d.delete(); prev_gnt_a = 2'b00;
      end else begin
        if (prev_gnt_a == 2'b00 && a_gnt != 2'b00) begin
          if (ex_id.size() == 0) begin
            check("grant_unexpected", a_gnt, 0);
          end else begin
            cur_id = ex_id.pop_front(); cur_len = ex_len.pop_front(); words_a = 0;
            check("grant_order", a_gnt, 1 << cur_id);
          end
        end
        if (a_tx_ack != 2'b00) begin
          m_id = a_tx_ack[1] ? 1 : 0;
          acks_a++;
          sb_id.push_back(m_id);
          sb_d.push_back(word(m_id, wcnt[0][m_id]));
        end
        if (a_rx_valid != 2'b00) begin
          if (sb_id.size() == 0) begin
            check("rx_unexpected", a_rx_valid, 0);
          end else begin
            m_id = sb_id.pop_front(); m_d = sb_d.pop_front();
            check("rx_data", a_rx_data, m_d);
            check("rx_valid_who", a_rx_valid, 1 << m_id);
            words_a++;
            check("back_to_back", a_tx_ack, (words_a < cur_len) ? a_gnt : 2'b00);
          end
        end
        if (a_xfer_done != 2'b00) begin
          check("xfer_done_who", a_xfer_done, 1 << cur_id);
          check("word_count", words_a, cur_len);
        end
        prev_gnt_a = a_gnt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input int id, input int len);
    ex_id.push_back(id);
    ex_len.push_back(len);
  endtask

  task automatic wait_grant();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (a_gnt != 2'b00);
    end
    if (!ok) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_all_granted();
    bit ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      tick();
      ok = (ex_id.size() == 0 && a_gnt != 2'b00);
    end
    if (!ok) check("sequence_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      ok = !a_busy && !b_busy;
    end
    if (!ok) check("idle_timeout", 0, 1);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  int w0;
  int base;
  bit ok5;

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("rst_ss_n", a_ss_n, 2'b11);
    check("rst_gnt", a_gnt, 0);
    check("rst_busy", a_busy, 0);
    check("rst_rx_data", a_rx_data, 0);
    check("rst_core_wr", a_core_wr, 0);
    check("rst_core_cs", a_core_cs, 0);
    check("rst_xfer_done", a_xfer_done, 0);
    check("rst_tx_ack", a_tx_ack, 0);
    check("rst_rx_valid", a_rx_valid, 0);
    check("rst_ss_n_b", b_ss_n, 2'b11);
    rst = 1'b1;
    tick();

    // Three words from requester 0.
    req_len[7:0] = 8'd3;
    expect_xfer(0, 3);
    req = 2'b01;
    wait_grant();
    req = 2'b00;
    check("single_ss_n", a_ss_n, 2'b10);
    wait_idle();
    check("single_last_rx", a_rx_data, 8'hFF);

    // Simultaneous held requests alternate, starting with requester 0.
    do_reset();
    req_len = {8'd1, 8'd1};
    expect_xfer(0, 1); expect_xfer(1, 1); expect_xfer(0, 1); expect_xfer(1, 1);
    req = 2'b11;
    wait_all_granted();
    req = 2'b00;
    wait_idle();

    // Zero-length transaction on requester 1.
    req_len[15:8] = 8'd0;
    expect_xfer(1, 0);
    w0 = wr_cnt[0];
    req = 2'b10;
    wait_grant();
    req = 2'b00;
    check("zero_len_ss_n", a_ss_n, 2'b01);
    wait_idle();
    check("zero_len_no_wr", wr_cnt[0], w0);

    // Request dropped right after grant still completes both words.
    req_len[7:0] = 8'd2;
    expect_xfer(0, 2);
    req = 2'b01;
    wait_grant();
    req = 2'b00;
    wait_idle();

    // Reset while waiting on word 2 of 4.
    req_len[7:0] = 8'd4;
    expect_xfer(0, 4);
    base = acks_a;
    req = 2'b01;
    wait_grant();
    req = 2'b00;
    ok5 = 1'b0;
    for (int i = 0; i < 200 && !ok5; i++) begin
      tick();
      ok5 = (acks_a >= base + 2);
    end
    if (!ok5) check("second_word_timeout", 0, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("abort_ss_n", a_ss_n, 2'b11);
    check("abort_gnt", a_gnt, 0);
    check("abort_busy", a_busy, 0);
    check("abort_xfer_done", a_xfer_done, 0);
    check("abort_ss_n_b", b_ss_n, 2'b11);
    rst = 1'b1;
    tick();
    req_len[7:0] = 8'd1;
    expect_xfer(0, 1);
    req = 2'b01;
    wait_grant();
    req = 2'b00;
    wait_idle();

    // Back-to-back transactions from the same requester.
    req_len[7:0] = 8'd1;
    expect_xfer(0, 1); expect_xfer(0, 1);
    req = 2'b01;
    wait_all_granted();
    req = 2'b00;
    wait_idle();
    check("all_expected_consumed", ex_id.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
